// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings, FSM state type and lane/size helpers for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  // Physical HWDATA byte lanes touched by a transfer; big-endian mirrors the lanes.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] ofs,
                                         input logic big_endian);
    logic [3:0] be_s;
    be_s = 4'b0000;
    case (size)
      HSIZE_BYTE: be_s = 4'b0001 << ofs;
      HSIZE_HALF: be_s = ofs[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be_s = 4'b1111;
      default:    be_s = 4'b0000;
    endcase
    if (big_endian) begin
      be_s = {be_s[0], be_s[1], be_s[2], be_s[3]};
    end else begin
      be_s = be_s;
    end
    return be_s;
  endfunction

  // Unsupported size or misaligned half/word access.
  function automatic logic size_addr_bad(input logic [2:0] size, input logic [1:0] ofs);
    logic bad_s;
    case (size)
      HSIZE_BYTE: bad_s = 1'b0;
      HSIZE_HALF: bad_s = ofs[0];
      HSIZE_WORD: bad_s = (ofs != 2'b00);
      default:    bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-wide SRAM bank: byte-enable writes, registered read with same-edge write forwarding.
// The read register clears when neither loading nor holding, so idle read data is zero.
module ahb_sram_bank #(
  parameter int WORDS = 64,
  parameter int WAW   = 6
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic           we,
  input  logic [3:0]     be,
  input  logic [WAW-1:0] waddr,
  input  logic [31:0]    wdata,
  input  logic           rd_load,
  input  logic           rd_hold,
  input  logic [WAW-1:0] raddr,
  output logic [31:0]    rdata
);

  logic [31:0] mem [WORDS];
  logic [31:0] mem_word_s;
  logic [31:0] fwd_s;
  logic        hit_s;

  assign mem_word_s = mem[raddr];
  assign hit_s      = we && (waddr == raddr);

  // Byte-lane write into the array; contents are never reset.
  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Forward lanes committed on the same edge so a back-to-back read sees new data.
  always_comb begin
    fwd_s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      fwd_s[8*i +: 8] = (hit_s && be[i]) ? wdata[8*i +: 8] : mem_word_s[8*i +: 8];
    end
  end

  // Read data register: load on read accept, hold across wait states, otherwise zero.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rdata <= 32'h0000_0000;
    end else if (rd_load) begin
      rdata <= fwd_s;
    end else if (rd_hold) begin
      rdata <= rdata;
    end else begin
      rdata <= 32'h0000_0000;
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: accept/error decode, wait-state FSM, lane decode around one SRAM bank.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] DEPTH_IN_BYTES = 32'h100,
  parameter int          WAIT_STATES    = 0,
  parameter bit          BIG_ENDIAN     = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP
);

  localparam int          AW     = $clog2(DEPTH_IN_BYTES);
  localparam int          WORDS  = int'(DEPTH_IN_BYTES >> 2);
  localparam int          WAW    = (AW > 2) ? (AW - 2) : 1;
  localparam logic [3:0]  WS_CNT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_e         state_r, state_nxt_s;
  logic [3:0]     cnt_r, cnt_nxt_s;
  logic           hreadyout_r, hreadyout_nxt_s;
  logic [1:0]     hresp_r, hresp_nxt_s;

  logic           valid_q, write_q;
  logic [2:0]     size_q;
  logic [1:0]     ofs_q;
  logic [WAW-1:0] widx_q;

  logic [31:0]    haddr_wrd_s;
  logic           accept_s, bad_s, we_s, rd_load_s, rd_hold_s;
  logic [3:0]     be_s;
  logic           unused_s;

  // Offset modulo memory size; bits above the word index are don't-care.
  assign haddr_wrd_s = (HADDR & (DEPTH_IN_BYTES - 32'd1)) >> 2;
  assign unused_s    = ^{HPROT, HBURST, HTRANS[0], haddr_wrd_s};

  assign accept_s  = HSEL && HREADY && HTRANS[1] && hreadyout_r;
  assign bad_s     = size_addr_bad(HSIZE, HADDR[1:0]);
  assign we_s      = valid_q && write_q && hreadyout_r;
  assign be_s      = lane_be(size_q, ofs_q, BIG_ENDIAN);
  assign rd_load_s = accept_s && !bad_s && !HWRITE;
  assign rd_hold_s = (state_r == ST_WAIT);

  // Next-state, wait counter and next registered response values.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    hreadyout_nxt_s = 1'b1;
    hresp_nxt_s     = HRESP_OKAY;
    case (state_r)
      ST_IDLE, ST_ERR2: begin
        if (accept_s && bad_s) begin
          state_nxt_s = ST_ERR1;
        end else if (accept_s && (WAIT_STATES > 0)) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = WS_CNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
    case (state_nxt_s)
      ST_WAIT: begin
        hreadyout_nxt_s = 1'b0;
        hresp_nxt_s     = HRESP_OKAY;
      end
      ST_ERR1: begin
        hreadyout_nxt_s = 1'b0;
        hresp_nxt_s     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_ERROR;
      end
      default: begin
        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = HRESP_OKAY;
      end
    endcase
  end

  // FSM state, wait counter and registered response outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hreadyout_r <= hreadyout_nxt_s;
      hresp_r     <= hresp_nxt_s;
    end
  end

  // Address-phase capture; any pending data phase completes whenever HREADYOUT is high.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      ofs_q   <= 2'b00;
      widx_q  <= '0;
    end else if (hreadyout_r) begin
      valid_q <= accept_s && !bad_s;
      if (accept_s) begin
        write_q <= HWRITE;
        size_q  <= HSIZE;
        ofs_q   <= HADDR[1:0];
        widx_q  <= haddr_wrd_s[WAW-1:0];
      end
    end
  end

  ahb_sram_bank #(
    .WORDS (WORDS),
    .WAW   (WAW)
  ) u_bank (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .we      (we_s),
    .be      (be_s),
    .waddr   (widx_q),
    .wdata   (HWDATA),
    .rd_load (rd_load_s),
    .rd_hold (rd_hold_s),
    .raddr   (haddr_wrd_s[WAW-1:0]),
    .rdata   (HRDATA)
  );

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;

endmodule
